// File: rtl/leitor_lcd.sv
// leitor_lcd: status and DDRAM reads on the 8-bit HD44780 bus; result on Valido (30 / 117+ cycles at defaults).
// Requests are accepted only while Pronto; optional busy-poll timeout enabled by LEITOR_TIMEOUT_EN.
module leitor_lcd #(
    parameter int T_AS      = 2,
    parameter int T_PW      = 12,
    parameter int T_H       = 2,
    parameter int T_GAP     = 13,
    parameter int T_TIMEOUT = 4096
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Inicializado,
    input  logic       Requisicao,
    input  logic       Tipo,
    input  logic [6:0] Endereco,
    input  logic [7:0] Dados_in,
    output logic       Enable,
    output logic       RS,
    output logic       RW,
    output logic [7:0] Dados_out,
    output logic       Dados_oe,
    output logic       Pronto,
    output logic       Ocupado,
    output logic       Valido,
    output logic [7:0] Dado_lido,
    output logic [6:0] Endereco_atual,
    output logic       Erro
);
    typedef enum logic [2:0] {OCIOSO, SETUP, PULSO, HOLD, GAP} estado_t;
    typedef enum logic [2:0] {F_STATUS, F_POLL1, F_ESCRITA, F_POLL2, F_LEITURA} fase_t;

    localparam logic [15:0] FIM_AS  = 16'(T_AS - 1);
    localparam logic [15:0] FIM_PW  = 16'(T_PW - 1);
    localparam logic [15:0] FIM_H   = 16'(T_H - 1);
    localparam logic [15:0] FIM_GAP = 16'(T_GAP - 1);

    estado_t     estado_q, estado_d;
    fase_t       fase_q, fase_d;
    logic [15:0] cnt_q, cnt_d;
    logic [6:0]  end_q, end_d;
    logic        bf_q, bf_d;
    logic        valido_q, valido_d;
    logic        erro_q, erro_d;
    logic [7:0]  dado_q, dado_d;
    logic [6:0]  ac_q, ac_d;
    logic        expirou;
    logic        em_acesso;

`ifdef LEITOR_TIMEOUT_EN
    localparam int TW = $clog2(T_TIMEOUT + 1);
    logic [TW-1:0] to_q, to_d;

    assign expirou = (to_q == TW'(T_TIMEOUT));

    // Restarts on every poll-phase entry; saturates once the limit is reached.
    always_comb begin
        to_d = to_q;
        if (estado_q == OCIOSO || fase_d != fase_q)
            to_d = '0;
        else if ((fase_q == F_POLL1 || fase_q == F_POLL2) && !expirou)
            to_d = to_q + 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Reset) to_q <= '0;
        else       to_q <= to_d;
    end
`else
    logic unused_timeout;
    assign expirou        = 1'b0;
    assign unused_timeout = (T_TIMEOUT != 0);
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado_q <= OCIOSO;
            fase_q   <= F_STATUS;
            cnt_q    <= '0;
            end_q    <= '0;
            bf_q     <= 1'b0;
            valido_q <= 1'b0;
            erro_q   <= 1'b0;
            dado_q   <= '0;
            ac_q     <= '0;
        end else begin
            estado_q <= estado_d;
            fase_q   <= fase_d;
            cnt_q    <= cnt_d;
            end_q    <= end_d;
            bf_q     <= bf_d;
            valido_q <= valido_d;
            erro_q   <= erro_d;
            dado_q   <= dado_d;
            ac_q     <= ac_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        fase_d   = fase_q;
        cnt_d    = cnt_q + 16'd1;
        end_d    = end_q;
        bf_d     = bf_q;
        valido_d = 1'b0;
        erro_d   = 1'b0;
        dado_d   = dado_q;
        ac_d     = ac_q;
        case (estado_q)
            OCIOSO: begin
                cnt_d = '0;
                if (Requisicao && Pronto) begin
                    estado_d = SETUP;
                    end_d    = Endereco;
                    fase_d   = Tipo ? F_POLL1 : F_STATUS;
                end
            end
            SETUP: if (cnt_q == FIM_AS) begin
                estado_d = PULSO;
                cnt_d    = '0;
            end
            PULSO: if (cnt_q == FIM_PW) begin
                estado_d = HOLD;
                cnt_d    = '0;
                // Only the last access of an operation may touch Dado_lido.
                if (fase_q == F_LEITURA) begin
                    dado_d = Dados_in;
                end else if (fase_q != F_ESCRITA) begin
                    bf_d = Dados_in[7];
                    ac_d = Dados_in[6:0];
                    if (fase_q == F_STATUS) dado_d = Dados_in;
                end
            end
            HOLD: if (cnt_q == FIM_H) begin
                estado_d = GAP;
                cnt_d    = '0;
            end
            GAP: if (cnt_q == FIM_GAP) begin
                estado_d = SETUP;
                cnt_d    = '0;
                case (fase_q)
                    F_STATUS, F_LEITURA: begin
                        estado_d = OCIOSO;
                        valido_d = 1'b1;
                    end
                    F_POLL1, F_POLL2: begin
                        if (bf_q && expirou) begin
                            estado_d = OCIOSO;
                            erro_d   = 1'b1;
                        end else if (!bf_q) begin
                            fase_d = (fase_q == F_POLL1) ? F_ESCRITA : F_LEITURA;
                        end
                    end
                    F_ESCRITA: fase_d = F_POLL2;
                    default:   estado_d = OCIOSO;
                endcase
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_comb begin
        em_acesso      = (estado_q == SETUP) || (estado_q == PULSO) || (estado_q == HOLD);
        Enable         = (estado_q == PULSO);
        RS             = em_acesso && (fase_q == F_LEITURA);
        RW             = em_acesso && (fase_q != F_ESCRITA);
        Dados_oe       = em_acesso && (fase_q == F_ESCRITA);
        Dados_out      = (em_acesso && fase_q == F_ESCRITA) ? {1'b1, end_q} : 8'h00;
        Pronto         = (estado_q == OCIOSO) && Inicializado;
        Ocupado        = (estado_q != OCIOSO);
        Valido         = valido_q;
        Erro           = erro_q;
        Dado_lido      = dado_q;
        Endereco_atual = ac_q;
    end
endmodule

// File: tb/tb_leitor_lcd.sv
// Bench for leitor_lcd: directed reads against a small LCD model, scoreboard-checked completions.
module tb_leitor_lcd;
    logic       clk = 1'b0;
    logic       Reset, Inicializado, Requisicao, Tipo;
    logic [6:0] Endereco;
    logic [7:0] Dados_in;
    logic       Enable, RS, RW, Dados_oe, Pronto, Ocupado, Valido, Erro;
    logic [7:0] Dados_out, Dado_lido;
    logic [6:0] Endereco_atual;

    leitor_lcd #(.T_TIMEOUT(100)) dut (
        .Clock(clk), .Reset(Reset), .Inicializado(Inicializado), .Requisicao(Requisicao),
        .Tipo(Tipo), .Endereco(Endereco), .Dados_in(Dados_in), .Enable(Enable), .RS(RS),
        .RW(RW), .Dados_out(Dados_out), .Dados_oe(Dados_oe), .Pronto(Pronto),
        .Ocupado(Ocupado), .Valido(Valido), .Dado_lido(Dado_lido),
        .Endereco_atual(Endereco_atual), .Erro(Erro)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // LCD model: status reads return {BF, AC}; BF stays 1 for busy_left status reads.
    int         busy_left = 0;
    logic [6:0] ac_val = 7'h00;
    logic [7:0] data_byte = 8'h00;
    logic [7:0] exp_wr = 8'h00;
    assign Dados_in = RS ? data_byte : {busy_left != 0, ac_val};
    always @(negedge Enable) if (!RS && RW && busy_left > 0) busy_left = busy_left - 1;

    typedef struct {
        int         acc;
        int         lat;
        logic       erro;
        logic [7:0] dado;
        logic [6:0] ac;
        int         pulses;
        int         stat;
        int         encyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: per-operation bus statistics, popped and compared on every completion strobe.
    int   npulse = 0, nstat = 0, nen = 0, first_en = -1;
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (Reset) begin
            npulse = 0; nstat = 0; nen = 0; first_en = -1; prev_en = 1'b0;
        end else begin
            if (Enable) begin
                if (!prev_en) begin
                    npulse++;
                    if (!RS && RW) nstat++;
                end
                nen++;
                if (first_en < 0) first_en = cyc;
            end
            prev_en = Enable;
            if (Dados_oe) begin
                chk("wr_byte", Dados_out, exp_wr);
                chk("wr_rs_rw", {RS, RW}, 2'b00);
            end
            if (Enable && RS) chk("rd_rw", RW, 1);
            if (Valido || Erro) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: Valido=%0b Erro=%0b with nothing pending", Valido, Erro);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc - e.acc, e.lat);
                    chk("valido", Valido, !e.erro);
                    chk("erro", Erro, e.erro);
                    chk("dado_lido", Dado_lido, e.dado);
                    chk("endereco_atual", Endereco_atual, e.ac);
                    chk("en_pulses", npulse, e.pulses);
                    chk("status_reads", nstat, e.stat);
                    chk("en_cycles", nen, e.encyc);
                    chk("first_en", first_en - e.acc, 3);
                end
                npulse = 0; nstat = 0; nen = 0; first_en = -1;
            end
        end
    end

    task automatic req(input logic tipo, input logic [6:0] ad, output int acc);
        int n = 0;
        while (!Pronto && n < 1000) begin @(negedge clk); n++; end
        if (!Pronto) begin
            checks++; failures++;
            $display("FAIL req_ready: Pronto=%0b expected 1", Pronto);
        end
        Requisicao = 1'b1; Tipo = tipo; Endereco = ad; acc = cyc;
        @(negedge clk);
        Requisicao = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL op_done: %0d pending after %0d cycles, expected 0", sb.size(), n);
            sb.delete();
        end
    endtask

    initial begin
        int   acc;
        int   n;
        exp_t e;
        Reset = 1'b1; Inicializado = 1'b0; Requisicao = 1'b0; Tipo = 1'b0; Endereco = 7'h00;
        repeat (3) @(negedge clk);
        Reset = 1'b0; Inicializado = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", {Enable, RS, RW, Dados_oe, Valido, Erro, Ocupado}, 7'b0);
        chk("rst_dados_out", Dados_out, 8'h00);
        chk("rst_dado_lido", Dado_lido, 8'h00);
        chk("rst_end_atual", Endereco_atual, 7'h00);
        chk("rst_pronto", Pronto, 1);

        // Status read returning 8'h25.
        ac_val = 7'h25; busy_left = 0;
        req(1'b0, 7'h00, acc);
        chk("ocupado_busy", Ocupado, 1);
        e = '{acc, 30, 1'b0, 8'h25, 7'h25, 1, 1, 12};
        sb.push_back(e);
        wait_done();

        // DDRAM read at 0x40, never busy.
        data_byte = 8'h41; exp_wr = 8'hC0;
        req(1'b1, 7'h40, acc);
        e = '{acc, 117, 1'b0, 8'h41, 7'h25, 4, 2, 48};
        sb.push_back(e);
        wait_done();

        // DDRAM read at 0x7F with 3 busy polls, stray request and Inicializado drop mid-operation.
        data_byte = 8'h5A; exp_wr = 8'hFF; ac_val = 7'h13; busy_left = 3;
        req(1'b1, 7'h7F, acc);
        e = '{acc, 204, 1'b0, 8'h5A, 7'h13, 7, 5, 84};
        sb.push_back(e);
        repeat (4) @(negedge clk);
        Requisicao = 1'b1; Tipo = 1'b0;
        @(negedge clk);
        Requisicao = 1'b0;
        repeat (30) @(negedge clk);
        Inicializado = 1'b0;
        repeat (100) @(negedge clk);
        Inicializado = 1'b1;

        // Next request issued in the very cycle Valido is high.
        n = 0;
        while (!Valido && n < 300) begin @(negedge clk); n++; end
        if (!Valido) begin
            checks++; failures++;
            $display("FAIL valido_wait: Valido=%0b expected 1", Valido);
        end
        ac_val = 7'h55; busy_left = 2;
        Requisicao = 1'b1; Tipo = 1'b0; acc = cyc;
        e = '{acc, 30, 1'b0, 8'hD5, 7'h55, 1, 1, 12};
        sb.push_back(e);
        @(negedge clk);
        Requisicao = 1'b0;
        wait_done();
        busy_left = 0;

        // Requests while not initialised are dropped.
        Inicializado = 1'b0;
        @(negedge clk);
        chk("pronto_uninit", Pronto, 0);
        Requisicao = 1'b1; Tipo = 1'b1;
        repeat (3) @(negedge clk);
        Requisicao = 1'b0;
        repeat (40) @(negedge clk);
        chk("ocupado_uninit", Ocupado, 0);
        Inicializado = 1'b1;

`ifdef LEITOR_TIMEOUT_EN
        // BF stuck at 1: abort after the limit with a single Erro strobe.
        ac_val = 7'h0A; busy_left = 1000;
        req(1'b1, 7'h22, acc);
        e = '{acc, 117, 1'b1, 8'hD5, 7'h0A, 4, 4, 48};
        sb.push_back(e);
        wait_done();
        @(negedge clk);
        chk("pronto_after_to", Pronto, 1);
        busy_left = 0;
`endif

        // Reset in the middle of the Enable pulse.
        ac_val = 7'h31;
        req(1'b0, 7'h00, acc);
        n = 0;
        while (!Enable && n < 50) begin @(negedge clk); n++; end
        chk("en_before_rst", Enable, 1);
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctrl", {Enable, RS, RW, Dados_oe, Valido, Erro, Ocupado}, 7'b0);
        chk("rst_mid_dado", Dado_lido, 8'h00);
        chk("rst_mid_ac", Endereco_atual, 7'h00);
        @(negedge clk);
        Reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("ocupado_after_rst", Ocupado, 0);
        chk("pronto_after_rst", Pronto, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
